// File: rtl/fft_pkg.sv
// Shared constants, state encoding and helpers for the 8-point FFT sequencer.
package fft_pkg;

    localparam int LOG2N  = 3;
    localparam int ADDR_W = 3;
    localparam int TW_W   = 2;

    typedef enum logic [1:0] {
        LOAD,
        ISSUE,
        WAIT,
        OUTPUT
    } fft_state_e;

    function automatic logic [ADDR_W-1:0] bit_rev(input logic [ADDR_W-1:0] v);
        logic [ADDR_W-1:0] r;
        for (int i = 0; i < ADDR_W; i++) begin
            r[i] = v[ADDR_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_ctrl_if.sv
// Sample-in, butterfly-issue and result-out signals between fft_ctrl and its datapath.
interface fft_ctrl_if;
    import fft_pkg::*;

    logic              sample_valid;
    logic              sample_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              bfly_valid;
    logic [ADDR_W-1:0] bfly_addr_a;
    logic [ADDR_W-1:0] bfly_addr_b;
    logic [TW_W-1:0]   twiddle_idx;
    logic [1:0]        stage;
    logic              res_valid;
    logic              res_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              busy;
    logic              done;

    modport master (
        input  sample_valid, res_ready,
        output sample_ready, wr_en, wr_addr, bfly_valid, bfly_addr_a, bfly_addr_b,
               twiddle_idx, stage, res_valid, rd_addr, busy, done
    );

    modport slave (
        output sample_valid, res_ready,
        input  sample_ready, wr_en, wr_addr, bfly_valid, bfly_addr_a, bfly_addr_b,
               twiddle_idx, stage, res_valid, rd_addr, busy, done
    );

endinterface

// File: rtl/fft_addr_gen.sv
// Combinational DIT butterfly address/twiddle mapping from (stage, k).
module fft_addr_gen
    import fft_pkg::*;
(
    input  logic [1:0]        stage,
    input  logic [1:0]        k,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic [TW_W-1:0]   tw
);

    logic [ADDR_W-1:0] k_ext;
    logic [ADDR_W-1:0] half;
    logic [ADDR_W-1:0] group;
    logic [ADDR_W-1:0] pos;

    always_comb begin
        k_ext  = {1'b0, k};
        half   = ADDR_W'(1) << stage;
        group  = k_ext >> stage;
        pos    = k_ext & (half - ADDR_W'(1));
        // group * 2 * half folded into one shift
        addr_a = (group << (stage + 2'd1)) + pos;
        addr_b = addr_a + half;
        tw     = TW_W'(pos << (2'd2 - stage));
    end

endmodule

// File: rtl/fft_ctrl.sv
// 8-point radix-2 FFT sequencer: load, 3x4 butterfly issue with write-back gaps, result stream.
// Optional FFT_CTRL_BITREV_EN: write samples to bit-reversed addresses for in-place DIT.
module fft_ctrl
    import fft_pkg::*;
#(
    parameter int unsigned N_POINTS = 8,
    parameter int unsigned BFLY_LAT = 2
) (
    input logic        CLK,
    input logic        RST,
    fft_ctrl_if.master bus
);

    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(N_POINTS - 1);
    localparam logic [1:0]        LAST_STAGE = 2'(LOG2N - 1);
    localparam logic [1:0]        LAST_K     = 2'd3;
    localparam int unsigned       WAIT_W     = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;
    localparam logic [WAIT_W-1:0] LAST_WAIT  = WAIT_W'(BFLY_LAT - 1);

    fft_state_e        state_q, state_d;
    logic [ADDR_W-1:0] n_q, n_d;
    logic [1:0]        k_q, k_d;
    logic [1:0]        stage_q, stage_d;
    logic [WAIT_W-1:0] w_q, w_d;
    logic [ADDR_W-1:0] r_q, r_d;

    logic              sample_ready;
    logic              wr_en;
    logic              bfly_valid;
    logic              res_valid;
    logic              done;
    logic [ADDR_W-1:0] gen_a;
    logic [ADDR_W-1:0] gen_b;
    logic [TW_W-1:0]   gen_tw;

    fft_addr_gen u_addr_gen (
        .stage  (stage_q),
        .k      (k_q),
        .addr_a (gen_a),
        .addr_b (gen_b),
        .tw     (gen_tw)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= LOAD;
            n_q     <= '0;
            k_q     <= '0;
            stage_q <= '0;
            w_q     <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            stage_q <= stage_d;
            w_q     <= w_d;
            r_q     <= r_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        k_d          = k_q;
        stage_d      = stage_q;
        w_d          = w_q;
        r_d          = r_q;
        sample_ready = 1'b0;
        wr_en        = 1'b0;
        bfly_valid   = 1'b0;
        res_valid    = 1'b0;
        done         = 1'b0;

        unique case (state_q)
            LOAD: begin
                sample_ready = 1'b1;
                wr_en        = bus.sample_valid;
                if (wr_en) begin
                    if (n_q == LAST_IDX) begin
                        n_d     = '0;
                        k_d     = '0;
                        stage_d = '0;
                        state_d = ISSUE;
                    end else begin
                        n_d = n_q + ADDR_W'(1);
                    end
                end
            end
            ISSUE: begin
                bfly_valid = 1'b1;
                if (k_q == LAST_K) begin
                    k_d     = '0;
                    w_d     = '0;
                    state_d = WAIT;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            WAIT: begin
                // Idle slots let the last butterfly write back before the next stage reads it
                if (w_q == LAST_WAIT) begin
                    w_d = '0;
                    if (stage_q == LAST_STAGE) begin
                        r_d     = '0;
                        state_d = OUTPUT;
                    end else begin
                        stage_d = stage_q + 2'd1;
                        state_d = ISSUE;
                    end
                end else begin
                    w_d = w_q + WAIT_W'(1);
                end
            end
            OUTPUT: begin
                res_valid = 1'b1;
                if (bus.res_ready) begin
                    if (r_q == LAST_IDX) begin
                        done    = 1'b1;
                        r_d     = '0;
                        n_d     = '0;
                        stage_d = '0;
                        state_d = LOAD;
                    end else begin
                        r_d = r_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    assign bus.sample_ready = sample_ready;
    assign bus.wr_en        = wr_en;
`ifdef FFT_CTRL_BITREV_EN
    assign bus.wr_addr      = bit_rev(n_q);
`else
    assign bus.wr_addr      = n_q;
`endif
    assign bus.bfly_valid   = bfly_valid;
    assign bus.bfly_addr_a  = bfly_valid ? gen_a : '0;
    assign bus.bfly_addr_b  = bfly_valid ? gen_b : '0;
    assign bus.twiddle_idx  = bfly_valid ? gen_tw : '0;
    assign bus.stage        = stage_q;
    assign bus.res_valid    = res_valid;
    assign bus.rd_addr      = res_valid ? r_q : '0;
    assign bus.busy         = (state_q != LOAD);
    assign bus.done         = done;

endmodule

// File: tb/tb_fft_ctrl.sv
// Self-checking bench for fft_ctrl: cycle model of the load/compute/output schedule plus literal pins.
module tb_fft_ctrl;

    localparam int BFLY_LAT = 2;
    localparam int SPAN     = 4 + BFLY_LAT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft_ctrl_if bus ();

    fft_ctrl #(
        .N_POINTS (8),
        .BFLY_LAT (BFLY_LAT)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int sv_mode = 0;
    int rr_mode = 0;

    int mdl_a [12];
    int mdl_b [12];
    int mdl_tw[12];
    int lit_a [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int lit_b [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int lit_tw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
`ifdef FFT_CTRL_BITREV_EN
    int lit_wr[8]  = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
    int lit_wr[8]  = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif

    int m_mode, m_n, m_cyc, m_r;
    int wr_cnt, bf_cnt, lat_cnt;
    int wr_log[8];
    int bf_a[12], bf_b[12], bf_tw[12];
    bit first_out;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_wr(input int n);
`ifdef FFT_CTRL_BITREV_EN
        return ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
`else
        return n;
`endif
    endfunction

    // Reference schedule: textbook in-place DIT loop nest over blocks of width 2*half
    initial begin
        int idx;
        idx = 0;
        for (int s = 0; s < 3; s++) begin
            for (int base = 0; base < 8; base += (2 << s)) begin
                for (int p = 0; p < (1 << s); p++) begin
                    mdl_a[idx]  = base + p;
                    mdl_b[idx]  = base + p + (1 << s);
                    mdl_tw[idx] = p * (4 >> s);
                    idx++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_sample_ready", int'(bus.sample_ready), 1);
            chk("rst_busy", int'(bus.busy), 0);
            chk("rst_bfly_valid", int'(bus.bfly_valid), 0);
            chk("rst_res_valid", int'(bus.res_valid), 0);
            chk("rst_done", int'(bus.done), 0);
            chk("rst_wr_addr", int'(bus.wr_addr), 0);
            chk("rst_stage", int'(bus.stage), 0);
            m_mode = 0; m_n = 0; m_cyc = 0; m_r = 0;
            wr_cnt = 0; bf_cnt = 0; lat_cnt = 0; first_out = 1'b1;
        end else begin
            if (bus.wr_en) begin
                if (wr_cnt < 8) wr_log[wr_cnt] = int'(bus.wr_addr);
                wr_cnt++;
            end
            if (bus.bfly_valid) begin
                if (bf_cnt < 12) begin
                    bf_a[bf_cnt]  = int'(bus.bfly_addr_a);
                    bf_b[bf_cnt]  = int'(bus.bfly_addr_b);
                    bf_tw[bf_cnt] = int'(bus.twiddle_idx);
                end
                bf_cnt++;
            end
            if (bus.busy && !bus.res_valid) lat_cnt++;

            case (m_mode)
                0: begin
                    chk("load_sample_ready", int'(bus.sample_ready), 1);
                    chk("load_busy", int'(bus.busy), 0);
                    chk("load_bfly_valid", int'(bus.bfly_valid), 0);
                    chk("load_res_valid", int'(bus.res_valid), 0);
                    chk("load_done", int'(bus.done), 0);
                    chk("load_wr_en", int'(bus.wr_en), int'(bus.sample_valid));
                    if (bus.sample_valid) begin
                        chk("load_wr_addr", int'(bus.wr_addr), exp_wr(m_n));
                        if (m_n == 7) begin
                            chk("frame_wr_count", wr_cnt, 8);
                            for (int i = 0; i < 8; i++) chk("wr_addr_seq", wr_log[i], lit_wr[i]);
                            m_mode = 1; m_cyc = 0; bf_cnt = 0; lat_cnt = 0; first_out = 1'b1;
                        end else begin
                            m_n++;
                        end
                    end
                end
                1: begin
                    int s, k;
                    s = m_cyc / SPAN;
                    k = m_cyc % SPAN;
                    chk("comp_busy", int'(bus.busy), 1);
                    chk("comp_sample_ready", int'(bus.sample_ready), 0);
                    chk("comp_wr_en", int'(bus.wr_en), 0);
                    chk("comp_res_valid", int'(bus.res_valid), 0);
                    chk("comp_done", int'(bus.done), 0);
                    chk("comp_bfly_valid", int'(bus.bfly_valid), (k < 4) ? 1 : 0);
                    if (k < 4) begin
                        chk("bfly_stage", int'(bus.stage), s);
                        chk("bfly_addr_a", int'(bus.bfly_addr_a), mdl_a[s*4+k]);
                        chk("bfly_addr_b", int'(bus.bfly_addr_b), mdl_b[s*4+k]);
                        chk("bfly_twiddle", int'(bus.twiddle_idx), mdl_tw[s*4+k]);
                    end
                    m_cyc++;
                    if (m_cyc == 3 * SPAN) begin
                        m_mode = 2; m_r = 0;
                    end
                end
                default: begin
                    if (first_out) begin
                        first_out = 1'b0;
                        chk("compute_latency", lat_cnt, 18);
                        chk("bfly_count", bf_cnt, 12);
                        for (int i = 0; i < 12; i++) begin
                            chk("sched_a", bf_a[i], lit_a[i]);
                            chk("sched_b", bf_b[i], lit_b[i]);
                            chk("sched_tw", bf_tw[i], lit_tw[i]);
                        end
                    end
                    chk("out_res_valid", int'(bus.res_valid), 1);
                    chk("out_busy", int'(bus.busy), 1);
                    chk("out_bfly_valid", int'(bus.bfly_valid), 0);
                    chk("out_wr_en", int'(bus.wr_en), 0);
                    chk("out_sample_ready", int'(bus.sample_ready), 0);
                    chk("out_rd_addr", int'(bus.rd_addr), m_r);
                    chk("out_done", int'(bus.done), (bus.res_ready && m_r == 7) ? 1 : 0);
                    if (bus.res_ready) begin
                        if (m_r == 7) begin
                            m_mode = 0; m_n = 0; wr_cnt = 0;
                        end else begin
                            m_r++;
                        end
                    end
                end
            endcase
        end
    end

    // Input driver: applies the requested pattern just after each rising edge
    initial begin
        int tick;
        tick = 0;
        bus.sample_valid = 1'b0;
        bus.res_ready    = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tick++;
            case (sv_mode)
                0:       bus.sample_valid = 1'b0;
                1:       bus.sample_valid = 1'b1;
                default: bus.sample_valid = (tick % 3 == 0);
            endcase
            case (rr_mode)
                0:       bus.res_ready = 1'b0;
                1:       bus.res_ready = 1'b1;
                default: bus.res_ready = (tick % 2 == 0);
            endcase
        end
    end

    // sel: 0 = busy, 1 = done, 2 = stage-1 butterfly issue
    task automatic wait_for(input string name, input int sel, input int bound);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < bound && !hit; i++) begin
            @(negedge clk);
            case (sel)
                0:       hit = bus.busy;
                1:       hit = bus.done;
                default: hit = bus.bfly_valid && (bus.stage == 2'd1);
            endcase
        end
        chk(name, int'(hit), 1);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        sv_mode = 1;

        // Frame 1: back-to-back load, sample_valid left high, res_ready toggling
        wait_for("f1_busy", 0, 20);
        rr_mode = 2;
        wait_for("f1_done", 1, 200);

        // Frame 2: gapped load, then reset in the middle of stage 1
        sv_mode = 2;
        rr_mode = 1;
        wait_for("f2_busy", 0, 60);
        wait_for("f2_stage1", 2, 40);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_busy", int'(bus.busy), 0);
        chk("async_bfly_valid", int'(bus.bfly_valid), 0);
        chk("async_sample_ready", int'(bus.sample_ready), 1);
        chk("async_stage", int'(bus.stage), 0);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        sv_mode = 1;

        // Frame 3: fresh load after reset must give a complete schedule
        wait_for("f3_busy", 0, 20);
        sv_mode = 0;
        wait_for("f3_done", 1, 100);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_ctrl.md
# fft_ctrl

Sequencer for the 8-point radix-2 FFT datapath behind the top-level serial sample input. Accepts 8 sample strobes into the sample RAM, schedules the 12 butterfly operations (3 stages × 4) onto the single shared butterfly unit with operand addresses and twiddle index, then streams the 8 results out in natural order under a valid/ready handshake. Sits between the sample deserializer and the butterfly/RAM datapath in `top`.

## Interface

- `N_POINTS`, 8 — transform size; fixed at 8, other values unsupported
- `BFLY_LAT`, 2 — butterfly unit pipeline latency in cycles, ≥1
- `CLK` in 1 — the single clock
- `RST` in 1 — asynchronous, active-high reset
- `sample_valid` in 1 — one deserialized sample present this cycle
- `sample_ready` out 1 — controller accepts a sample (LOAD state)
- `wr_en` out 1 — sample RAM write strobe, = `sample_valid & sample_ready`
- `wr_addr` out 3 — sample RAM write address
- `bfly_valid` out 1 — issue a butterfly this cycle
- `bfly_addr_a` out 3 — upper operand/result address
- `bfly_addr_b` out 3 — lower operand/result address
- `twiddle_idx` out 2 — W8^k index k
- `stage` out 2 — current stage 0..2
- `res_valid` out 1 — result address valid
- `res_ready` in 1 — consumer accepts result
- `rd_addr` out 3 — result RAM read address
- `busy` out 1 — high in every state except LOAD
- `done` out 1 — one-cycle pulse on the final result handshake

## Operation

- States: LOAD → ISSUE → WAIT → (ISSUE | OUTPUT) → LOAD.
- LOAD: `sample_ready`=1. Each accepted sample writes `wr_addr` from load counter n (0..7), then n++. On the 8th accept → ISSUE, stage=0, k=0.
- ISSUE: `bfly_valid`=1 every cycle, k=0..3. With half=1<<stage, group=k>>stage, pos=k&(half-1): `bfly_addr_a`=group·2·half+pos, `bfly_addr_b`=a+half, `twiddle_idx`=pos<<(2−stage). After k=3 → WAIT.
- WAIT: hold `bfly_valid`=0 for exactly BFLY_LAT cycles (write-back hazard). Then stage<2 → stage++, k=0, ISSUE; stage=2 → OUTPUT, r=0.
- OUTPUT: `res_valid`=1, `rd_addr`=r. On `res_valid & res_ready`: r++; on r=7 handshake pulse `done` → LOAD, n=0.
- `sample_valid` outside LOAD is ignored (`wr_en`=0); no samples are buffered.
- `res_ready` low holds `rd_addr` stable indefinitely.
- All address arithmetic is 3-bit unsigned; no wrap occurs within a legal sequence.

## Timing

- Reset values: state=LOAD, `sample_ready`=1, `busy`=0, `wr_addr`=0, all other outputs 0.
- `RST` mid-operation: immediate return to LOAD, all counters 0; partial loads/stages discarded.
- `wr_en`/`wr_addr` are combinational from state and counter (same-cycle write).
- Compute latency from the 8th accept to first `res_valid`: 3·(4+BFLY_LAT) cycles (18 at default).
- `busy` rises the cycle after the 8th accept and falls the cycle after `done`.
- Minimum frame: 8 + 3·(4+BFLY_LAT) + 8 cycles.

## Configuration

- `FFT_CTRL_BITREV_EN` defined: `wr_addr` = bit-reverse(n) ({n[0],n[1],n[2]}), so the DIT stages read bit-reversed input in place.
- Undefined: `wr_addr` = n; the upstream deserializer delivers samples pre-reordered. Scheduling is unchanged.

## Structure

- `fft_pkg`: `LOG2N`=3, `ADDR_W`=3, `TW_W`=2, state enum (`LOAD`, `ISSUE`, `WAIT`, `OUTPUT`).
- Sub-module `fft_addr_gen`: maps (stage, k) to `bfly_addr_a`, `bfly_addr_b`, `twiddle_idx`. Combinational; the FSM and counters stay in `fft_ctrl`.

## Test plan

- Reset then 8 back-to-back `sample_valid` → `wr_addr` sequence 0,4,2,6,1,5,3,7 (BITREV_EN) or 0..7; `busy`=1 on the next cycle.
- Full compute, BFLY_LAT=2 → 12 `bfly_valid` pulses in groups of 4 separated by 2 idle cycles; stage 0 pairs (0,1)(2,3)(4,5)(6,7) with tw 0; stage 1 (0,2)(1,3)(4,6)(5,7) with tw 0,2,0,2; stage 2 (0,4)(1,5)(2,6)(3,7) with tw 0,1,2,3.
- `res_ready` toggled every other cycle → `rd_addr` 0..7 each held until handshake; `done` one pulse with r=7; `sample_ready`=1 on the next cycle.
- `sample_valid` held high during ISSUE/WAIT/OUTPUT → `wr_en` stays 0; the next frame's load count starts at 0.
- `RST` asserted mid stage 1 → outputs return to reset values asynchronously; a fresh 8-sample load then yields a full, correct schedule.
- Samples gapped (`sample_valid` every 3rd cycle) → exactly 8 writes; ISSUE starts the cycle after the 8th accept.
